// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned BCD_W      = 4 * DIGITS_DEF;

  // 10^n, used for the overflow threshold.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // 4-bit add, no carry out to the neighbouring digit.
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  CLK100MHz,
  input  logic                  RST,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned IterW = $clog2(BIN_W + 1);
  localparam logic [BIN_W:0] OvfLim = (BIN_W + 1)'(pow10(DIGITS));

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [BcdW-1:0]     work_q, work_d;
  logic [BcdW-1:0]     work_adj;
  logic [IterW-1:0]    iter_q, iter_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_q[4*g +: 4]),
      .dout (work_adj[4*g +: 4])
    );
  end

  // Next-state logic: capture in IDLE, one bit per SHIFT cycle, publish in DONE.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin_in;
          work_d     = '0;
          iter_d     = IterW'(BIN_W);
          ovf_pend_d = ({1'b0, bin_in} >= OvfLim);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Bits leaving the top digit are dropped, giving bin_in mod 10^DIGITS.
        {work_d, shift_d} = {work_adj, shift_q} << 1;
        iter_d            = iter_q - IterW'(1);
        if (iter_q == IterW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = work_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    bcd_out = bcd_q;
    ovf     = ovf_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK100MHz) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned LAT    = BIN_W + 1;
  localparam int unsigned PERIOD = BIN_W + 2;

  logic              CLK100MHz;
  logic              RST;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [15:0]       bcd_out;
  logic              ovf;

  int checks;
  int failures;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .CLK100MHz (CLK100MHz),
    .RST       (RST),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
  );

  initial CLK100MHz = 1'b0;
  always #5 CLK100MHz = ~CLK100MHz;

  // Reference: decimal digits of v mod 10^DIGITS via plain division.
  function automatic logic [15:0] model_bcd(input int unsigned v);
    int unsigned r;
    logic [15:0] res;
    r   = v % 10000;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic model_ovf(input int unsigned v);
    return v >= 10000;
  endfunction

  // One conversion from IDLE; reports latency, busy cycles and the settled outputs.
  task automatic run_conv(input int unsigned v, output int lat, output int busy_n,
                          output logic [15:0] b, output logic o, output logic done_after,
                          output logic busy_after);
    @(negedge CLK100MHz);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    @(negedge CLK100MHz);
    start  = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge CLK100MHz);
      lat++;
    end
    if (done && busy) busy_n++;
    @(negedge CLK100MHz);
    b          = bcd_out;
    o          = ovf;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    RST    = 1'b1;
    start  = 1'b1;
    bin_in = BIN_W'(1234);
    @(negedge CLK100MHz);
    @(negedge CLK100MHz);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (bcd_out !== 16'h0000 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: bcd=%h ovf=%b required 0000 0", bcd_out, ovf);
    end
    RST   = 1'b0;
    start = 1'b0;
    @(negedge CLK100MHz);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_prio: busy=%b required 0", busy);
    end
  endtask

  task automatic test_zero();
    int lat, busy_n;
    logic [15:0] b;
    logic o, da, ba;
    run_conv(0, lat, busy_n, b, o, da, ba);
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL zero_latency: got=%0d required=%0d", lat, LAT);
    end
    checks++;
    if (busy_n != LAT) begin
      failures++;
      $display("FAIL zero_busy_cycles: got=%0d required=%0d", busy_n, LAT);
    end
    checks++;
    if (b !== 16'h0000 || o !== 1'b0) begin
      failures++;
      $display("FAIL zero_result: bcd=%h ovf=%b required 0000 0", b, o);
    end
    checks++;
    if (da !== 1'b0 || ba !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse: done=%b busy=%b after done, required 0 0", da, ba);
    end
  endtask

  task automatic test_values();
    int unsigned vals[$];
    int lat, busy_n;
    logic [15:0] b;
    logic o, da, ba;
    vals = '{1234, 9999, 10000, 16383, 1, 9, 10, 99, 100, 999, 1000};
    for (int i = 0; i < 20; i++) vals.push_back($urandom_range(0, 16383));
    foreach (vals[i]) begin
      run_conv(vals[i], lat, busy_n, b, o, da, ba);
      checks++;
      if (b !== model_bcd(vals[i]) || o !== model_ovf(vals[i])) begin
        failures++;
        $display("FAIL value_%0d: bcd=%h ovf=%b required %h %b", vals[i], b, o,
                 model_bcd(vals[i]), model_ovf(vals[i]));
      end
      checks++;
      if (lat != LAT) begin
        failures++;
        $display("FAIL value_latency_%0d: got=%0d required=%0d", vals[i], lat, LAT);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dones, first, second;
    logic [15:0] got1, got2;
    dones = 0; first = 0; second = 0; got1 = '0; got2 = '0;
    @(negedge CLK100MHz);
    start  = 1'b1;
    bin_in = BIN_W'(1234);
    @(negedge CLK100MHz);
    start  = 1'b0;
    bin_in = '0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        dones++;
        if (dones == 1) first = n;
        else if (dones == 2) second = n;
      end
      if (n == 16) got1 = bcd_out;
      if (n == 32) got2 = bcd_out;
      case (n)
        5:  begin start = 1'b1; bin_in = BIN_W'(42); end
        6:  start = 1'b0;
        15: begin start = 1'b1; bin_in = BIN_W'(42); end
        17: start = 1'b0;
        default: ;
      endcase
      @(negedge CLK100MHz);
    end
    checks++;
    if (dones != 2 || first != LAT || second != LAT + PERIOD) begin
      failures++;
      $display("FAIL ignore_dones: count=%0d at %0d,%0d required 2 at %0d,%0d", dones, first,
               second, LAT, LAT + PERIOD);
    end
    checks++;
    if (got1 !== 16'h1234) begin
      failures++;
      $display("FAIL ignore_first: bcd=%h required 1234", got1);
    end
    checks++;
    if (got2 !== 16'h0042) begin
      failures++;
      $display("FAIL ignore_second: bcd=%h required 0042", got2);
    end
  endtask

  task automatic test_reset_abort();
    int lat, busy_n, dones;
    logic [15:0] b;
    logic o, da, ba;
    run_conv(16000, lat, busy_n, b, o, da, ba);
    dones = 0;
    @(negedge CLK100MHz);
    start  = 1'b1;
    bin_in = BIN_W'(5678);
    @(negedge CLK100MHz);
    start  = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (done) dones++;
      if (n == 7) RST = 1'b1;
      if (n == 8) begin
        RST = 1'b0;
        checks++;
        if (busy !== 1'b0 || bcd_out !== 16'h0000 || ovf !== 1'b0) begin
          failures++;
          $display("FAIL abort_state: busy=%b bcd=%h ovf=%b required 0 0000 0", busy, bcd_out,
                   ovf);
        end
      end
      @(negedge CLK100MHz);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_done: count=%0d required 0", dones);
    end
    run_conv(5678, lat, busy_n, b, o, da, ba);
    checks++;
    if (b !== 16'h5678 || o !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart: bcd=%h ovf=%b required 5678 0", b, o);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned vals[$];
    int idx, cyc, last_done, limit;
    logic pend;
    for (int v = 0; v < 400; v++) vals.push_back(v);
    for (int v = 9400; v < 10000; v++) vals.push_back(v);
    idx = 0; cyc = 0; last_done = -1; pend = 1'b0;
    limit = vals.size() * PERIOD + 100;
    @(negedge CLK100MHz);
    start  = 1'b1;
    bin_in = BIN_W'(vals[0]);
    while (idx < vals.size() && cyc < limit) begin
      @(negedge CLK100MHz);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (bcd_out !== model_bcd(vals[idx]) || ovf !== model_ovf(vals[idx])) begin
          failures++;
          $display("FAIL b2b_%0d: bcd=%h ovf=%b required %h %b", vals[idx], bcd_out, ovf,
                   model_bcd(vals[idx]), model_ovf(vals[idx]));
        end
        idx++;
        if (idx < vals.size()) bin_in = BIN_W'(vals[idx]);
      end
      if (done) begin
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != PERIOD) begin
            failures++;
            $display("FAIL b2b_period: got=%0d required=%0d", cyc - last_done, PERIOD);
          end
        end
        last_done = cyc;
        pend = 1'b1;
      end
    end
    start = 1'b0;
    checks++;
    if (idx != vals.size()) begin
      failures++;
      $display("FAIL b2b_timeout: completed=%0d required=%0d", idx, vals.size());
    end
    repeat (PERIOD + 2) @(negedge CLK100MHz);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    start    = 1'b0;
    bin_in   = '0;
    test_reset();
    test_zero();
    test_values();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
